sysinfo_apb: RTL and testbench

Parametrised successor to the system version block: APB3 read-out of the FPGA version plus up to eight filtered board-identification channels, with change detection, a maskable interrupt, a scratch register and a 64-bit uptime counter with atomic read. Sits on the peripheral APB bus next to the other housekeeping slaves and samples static strap/ID pins from the board.

---
 rtl/sysinfo_apb.sv | 173 +++++++++++++++++
 tb/tb_sysinfo_apb.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sysinfo_apb.sv
// APB3 system-information slave: version/build/config read-out, filtered board-ID
// channels with change detection and interrupt, scratch register and 64-bit uptime.
module sysinfo_apb #(
   parameter int          ADDRWIDTH       = 16,
   parameter int          C_VER_MAJ       = 0,
   parameter int          C_VER_MIN       = 1,
   parameter logic [31:0] C_VER_BUILD     = 32'd0,
   parameter int          C_NUM_ID_CH     = 2,
   parameter int          C_ID_WIDTH      = 4,
   parameter int          C_FILTER_CYCLES = 16
) (
   input  logic                              pclk,
   input  logic                              preset,
   input  logic                              psel,
   input  logic [ADDRWIDTH-1:0]              paddr,
   input  logic                              penable,
   input  logic                              pwrite,
   input  logic [31:0]                       pwdata,
   output logic                              pready,
   output logic [31:0]                       prdata,
   output logic                              pslverr,
   input  logic [C_NUM_ID_CH*C_ID_WIDTH-1:0] id_pins,
   output logic                              irq
);

   localparam logic [15:0] FLT_LAST     = 16'(C_FILTER_CYCLES - 1);
   localparam logic [31:0] VERSION_WORD = {16'h0, 8'(C_VER_MAJ), 8'(C_VER_MIN)};
   localparam logic [31:0] CONFIG_WORD  = {8'h0, 8'(C_NUM_ID_CH), 8'h0, 8'(C_ID_WIDTH)};

   logic [31:0]                       word_idx;
   logic                              access;
   logic                              addr_ok;
   logic [31:0]                       rd_data;
   logic [C_NUM_ID_CH-1:0]            status_clr;
   logic [C_NUM_ID_CH-1:0]            valid_bus;
   logic [C_NUM_ID_CH-1:0]            change_bus;
   logic [C_NUM_ID_CH*C_ID_WIDTH-1:0] filt_bus;

   logic [31:0]            scratch_reg;
   logic [C_NUM_ID_CH-1:0] irq_en_reg;
   logic [63:0]            uptime_reg;
   logic [31:0]            shadow_hi_reg;

   // Byte lanes are not decoded; only whole-word accesses are meaningful.
   wire unused_addr_bits = ^paddr[1:0];

   assign word_idx = 32'(paddr[ADDRWIDTH-1:2]);
   assign access   = psel & penable & ~pready;

   assign status_clr = (access && pwrite && word_idx == 32'd4) ?
                       pwdata[C_NUM_ID_CH-1:0] : '0;

   // ------------------------------------------------------------------
   // ID channels: synchroniser, stability filter, valid/change flags
   // ------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < C_NUM_ID_CH; gi++) begin : g_ch
         (* syn_keep = "true" *) logic [C_ID_WIDTH-1:0] d1_reg;
         (* syn_keep = "true" *) logic [C_ID_WIDTH-1:0] d2_reg;
         logic [C_ID_WIDTH-1:0] cand_reg;
         logic [C_ID_WIDTH-1:0] filt_reg;
         logic [15:0]           cnt_reg;
         logic                  valid_reg;
         logic                  change_reg;
         logic                  load;

         assign load = (cnt_reg == FLT_LAST) &&
                       ((cand_reg != filt_reg) || !valid_reg);

         always_ff @(posedge pclk) begin
            if (preset) begin
               d1_reg     <= '0;
               d2_reg     <= '0;
               cand_reg   <= '0;
               filt_reg   <= '0;
               cnt_reg    <= '0;
               valid_reg  <= 1'b0;
               change_reg <= 1'b0;
            end else begin
               d1_reg <= id_pins[gi*C_ID_WIDTH +: C_ID_WIDTH];
               d2_reg <= d1_reg;
               if (d2_reg != cand_reg) begin
                  cand_reg <= d2_reg;
                  cnt_reg  <= '0;
               end else if (cnt_reg != FLT_LAST) begin
                  cnt_reg <= cnt_reg + 16'd1;
               end
               if (load) begin
                  filt_reg  <= cand_reg;
                  valid_reg <= 1'b1;
               end
               // A new qualification beats a simultaneous W1C clear.
               change_reg <= (load & valid_reg) | (change_reg & ~status_clr[gi]);
            end
         end

         assign filt_bus[gi*C_ID_WIDTH +: C_ID_WIDTH] = filt_reg;
         assign valid_bus[gi]  = valid_reg;
         assign change_bus[gi] = change_reg;
      end
   endgenerate

   // ------------------------------------------------------------------
   // Register read decode
   // ------------------------------------------------------------------
   always_comb begin
      rd_data = '0;
      addr_ok = (word_idx < 32'd8);
      case (word_idx)
         32'd0:   rd_data = VERSION_WORD;
         32'd1:   rd_data = C_VER_BUILD;
         32'd2:   rd_data = CONFIG_WORD;
         32'd3:   rd_data = scratch_reg;
         32'd4:   rd_data = {8'h0, 8'(valid_bus), 8'h0, 8'(change_bus)};
         32'd5:   rd_data = 32'(irq_en_reg);
         32'd6:   rd_data = uptime_reg[31:0];
         32'd7:   rd_data = shadow_hi_reg;
         default: rd_data = '0;
      endcase
      for (int n = 0; n < C_NUM_ID_CH; n++) begin
         if (word_idx == 32'(8 + n)) begin
            addr_ok = 1'b1;
            rd_data = valid_bus[n] ? 32'(filt_bus[n*C_ID_WIDTH +: C_ID_WIDTH]) : '0;
         end
      end
   end

   // ------------------------------------------------------------------
   // APB transfer handling and writable registers
   // ------------------------------------------------------------------
   always_ff @(posedge pclk) begin
      if (preset) begin
         pready        <= 1'b0;
         prdata        <= '0;
         pslverr       <= 1'b0;
         scratch_reg   <= '0;
         irq_en_reg    <= '0;
         shadow_hi_reg <= '0;
      end else begin
         pready  <= access;
         pslverr <= access & ~addr_ok;
         if (access) begin
            prdata <= (!pwrite && addr_ok) ? rd_data : '0;
            if (pwrite && addr_ok) begin
               case (word_idx)
                  32'd3:   scratch_reg <= pwdata;
                  32'd5:   irq_en_reg  <= pwdata[C_NUM_ID_CH-1:0];
                  default: ;
               endcase
            end
            // Low-word read freezes the high word so the pair reads atomically.
            if (!pwrite && word_idx == 32'd6)
               shadow_hi_reg <= uptime_reg[63:32];
         end
      end
   end

   always_ff @(posedge pclk) begin
      if (preset)
         uptime_reg <= '0;
      else
         uptime_reg <= uptime_reg + 64'd1;
   end

   always_ff @(posedge pclk) begin
      if (preset)
         irq <= 1'b0;
      else
         irq <= |(change_bus & irq_en_reg);
   end

endmodule

// File: tb/tb_sysinfo_apb.sv
// Scoreboard bench for sysinfo_apb: APB register map, ID filter timing, change/irq,
// uptime atomic read and reset behaviour.
module tb_sysinfo_apb;

   localparam int AW  = 16;
   localparam int NCH = 2;
   localparam int W   = 4;
   localparam int F   = 4;

   logic              pclk    = 1'b0;
   logic              preset  = 1'b1;
   logic              psel    = 1'b0;
   logic              penable = 1'b0;
   logic              pwrite  = 1'b0;
   logic [AW-1:0]     paddr   = '0;
   logic [31:0]       pwdata  = '0;
   logic              pready;
   logic [31:0]       prdata;
   logic              pslverr;
   logic [NCH*W-1:0]  id_pins = 8'h3A;
   logic              irq;

   typedef struct packed {
      logic        is_rd;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t  sb_q[$];
   string tag_q[$];
   int    n_cmp = 0;
   int    n_mis = 0;

   always #5 pclk = ~pclk;

   sysinfo_apb #(
      .ADDRWIDTH(AW), .C_VER_MAJ(2), .C_VER_MIN(5), .C_VER_BUILD(32'h1234),
      .C_NUM_ID_CH(NCH), .C_ID_WIDTH(W), .C_FILTER_CYCLES(F)
   ) dut (
      .pclk(pclk), .preset(preset), .psel(psel), .paddr(paddr), .penable(penable),
      .pwrite(pwrite), .pwdata(pwdata), .pready(pready), .prdata(prdata),
      .pslverr(pslverr), .id_pins(id_pins), .irq(irq)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called just after a falling edge; returns just after a falling edge with the bus idle.
   task automatic apb_xfer(input logic wr, input int idx, input logic [31:0] wdata,
                           input logic [31:0] exp_data, input logic exp_err, input string tag);
      int    cyc;
      exp_t  e;
      string t;
      sb_q.push_back('{is_rd: !wr, data: exp_data, err: exp_err});
      tag_q.push_back(tag);
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = AW'(idx * 4);
      pwdata  = wdata;
      @(negedge pclk);
      penable = 1'b1;
      cyc = 0;
      do begin
         @(negedge pclk);
         cyc++;
      end while (!pready && cyc < 8);
      chk({tag, "_wait"}, 64'(cyc), 64'd1);
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      if (pready) begin
         if (e.is_rd) chk(t, 64'(prdata), 64'(e.data));
         chk({t, "_err"}, 64'(pslverr), 64'(e.err));
         $display("txn %s %s idx=%0d data=0x%08h err=%0b", wr ? "WR" : "RD", t, idx,
                  wr ? wdata : prdata, pslverr);
      end
      @(negedge pclk);
      psel    = 1'b0;
      penable = 1'b0;
      pwrite  = 1'b0;
      chk({tag, "_drop"}, 64'(pready), 64'd0);
   endtask

   task automatic rd(input int idx, input logic [31:0] exp, input logic err, input string tag);
      apb_xfer(1'b0, idx, 32'h0, exp, err, tag);
   endtask

   task automatic wr(input int idx, input logic [31:0] data, input logic err, input string tag);
      apb_xfer(1'b1, idx, data, 32'h0, err, tag);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(negedge pclk);
      chk("rst_pready",  64'(pready),  64'd0);
      chk("rst_prdata",  64'(prdata),  64'd0);
      chk("rst_pslverr", 64'(pslverr), 64'd0);
      chk("rst_irq",     64'(irq),     64'd0);
      preset = 1'b0;

      rd(0, 32'h0000_0205, 1'b0, "version");
      rd(1, 32'h0000_1234, 1'b0, "build");
      rd(2, 32'h0002_0004, 1'b0, "config");
      rd(7, 32'h0,         1'b0, "uptime_hi_rst");
      rd(3, 32'h0,         1'b0, "scratch_rst");
      rd(5, 32'h0,         1'b0, "irq_en_rst");

      repeat (20) @(negedge pclk);
      rd(4, 32'h0003_0000, 1'b0, "status_valid");
      rd(8, 32'hA,         1'b0, "id_ch0");
      rd(9, 32'h3,         1'b0, "id_ch1");
      chk("irq_idle", 64'(irq), 64'd0);

      wr(5, 32'hFF, 1'b0, "irq_en_all");
      rd(5, 32'h3,  1'b0, "irq_en_mask");
      wr(5, 32'h1,  1'b0, "irq_en_ch0");

      // ch0 -> 5: irq must rise exactly F+3 edges after d1 captures the new value
      id_pins = 8'h35;
      for (int k = 1; k <= 8; k++) begin
         @(negedge pclk);
         if (k == 7) chk("irq_early", 64'(irq), 64'd0);
         if (k == 8) chk("irq_rise",  64'(irq), 64'd1);
      end
      rd(4, 32'h0003_0001, 1'b0, "status_change0");
      rd(8, 32'h5,         1'b0, "id_ch0_new");
      wr(4, 32'h1,         1'b0, "status_w1c");
      chk("irq_cleared", 64'(irq), 64'd0);

      // W1C commit edge coincides with the filter load edge
      id_pins = 8'h3C;
      repeat (5) @(negedge pclk);
      wr(4, 32'h1, 1'b0, "w1c_vs_set");
      rd(4, 32'h0003_0001, 1'b0, "set_wins");
      rd(8, 32'hC,         1'b0, "id_ch0_c");
      wr(4, 32'h1,         1'b0, "status_w1c2");
      rd(4, 32'h0003_0000, 1'b0, "status_clear");

      // 3-cycle glitch on ch1 must be rejected
      id_pins = 8'h7C;
      repeat (3) @(negedge pclk);
      id_pins = 8'h3C;
      repeat (20) @(negedge pclk);
      rd(9, 32'h3,         1'b0, "glitch_id_ch1");
      rd(4, 32'h0003_0000, 1'b0, "glitch_status");
      chk("glitch_irq", 64'(irq), 64'd0);

      // Uptime: low word read at 0xFFFFFFFF must freeze the pre-wrap high word
      force dut.uptime_reg = 64'h0000_0003_FFFF_FFFE;
      #1;
      release dut.uptime_reg;
      rd(6, 32'hFFFF_FFFF, 1'b0, "uptime_lo_max");
      rd(7, 32'h0000_0003, 1'b0, "uptime_hi_prewrap");

      wr(3, 32'hDEAD_BEEF, 1'b0, "scratch_wr");
      rd(3, 32'hDEAD_BEEF, 1'b0, "scratch_rd");
      rd(32'h20, 32'h0,    1'b1, "unmapped_rd");
      wr(32'h20, 32'h55,   1'b1, "unmapped_wr");
      rd(10, 32'h0,        1'b1, "id_beyond_nch");
      wr(1, 32'hFFFF,      1'b0, "build_wr");
      rd(1, 32'h0000_1234, 1'b0, "build_kept");

      // Reset asserted during the access phase of a SCRATCH write
      psel    = 1'b1;
      pwrite  = 1'b1;
      paddr   = AW'(3 * 4);
      pwdata  = 32'h1234_5678;
      @(negedge pclk);
      penable = 1'b1;
      preset  = 1'b1;
      @(negedge pclk);
      chk("rst_abort_pready", 64'(pready), 64'd0);
      psel    = 1'b0;
      penable = 1'b0;
      pwrite  = 1'b0;
      @(negedge pclk);
      preset  = 1'b0;
      rd(3, 32'h0, 1'b0, "scratch_after_rst");
      rd(4, 32'h0, 1'b0, "status_after_rst");
      repeat (20) @(negedge pclk);
      rd(4, 32'h0003_0000, 1'b0, "status_requal");
      rd(8, 32'hC,         1'b0, "id_ch0_requal");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
